// File: rtl/serial_adder_fsm_if.sv
// Handshake and operand/result bundle for serial_adder_fsm.
// The sub/ovf signals exist only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell plus a carry flop, WIDTH cycles per sum.
// Define SERIAL_ADDER_SUB_EN to add the subtract mode and overflow flag.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_fsm_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] sum_q;
  logic [CNTW-1:0]  cnt;
  logic             c;
  logic             c_nx;
  logic             s;
  logic             bbit;
  logic             cout_q;
  logic             accept;
  logic             last;

  assign accept = bus.start && (state != ADD);
  assign last   = (state == ADD) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE): if (bus.start) nxt = ADD;
      (state == ADD):  if (cnt == LAST) nxt = DONE;
      (state == DONE): nxt = bus.start ? ADD : IDLE;
      default:         nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ADD);
    bus.done = (state == DONE);
  end

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  logic ovf_q;
  // subtract is a + ~b + cin, so b is inverted one bit at a time
  assign bbit    = b_sr[0] ^ sub_q;
  assign bus.ovf = ovf_q;
`else
  assign bbit = b_sr[0];
`endif

  assign s    = a_sr[0] ^ bbit ^ c;
  assign c_nx = (a_sr[0] & bbit) | (a_sr[0] & c) | (bbit & c);

  always_comb begin
    r_nx = r_sr >> 1;
    r_nx[WIDTH-1] = s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      c    <= bus.cin;
      cnt  <= '0;
      r_sr <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q <= bus.sub;
`endif
    end else if (state == ADD) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nx;
      c    <= c_nx;
      cnt  <= cnt + CNTW'(1);
      if (last) begin
        sum_q  <= r_nx;
        cout_q <= c_nx;
`ifdef SERIAL_ADDER_SUB_EN
        // c is the carry into the MSB, c_nx the carry out of it
        ovf_q  <= c ^ c_nx;
`endif
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm at WIDTH=8 and WIDTH=1.
// Build with SERIAL_ADDER_SUB_EN to exercise subtract mode and ovf.
module tb_serial_adder_fsm;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp8_t;

  typedef struct {
    logic s;
    logic c;
  } exp1_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp8_t q8[$];
  exp1_t q1[$];

  serial_adder_fsm_if #(.WIDTH(8)) bus8 ();
  serial_adder_fsm_if #(.WIDTH(1)) bus1 ();

  serial_adder_fsm #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  serial_adder_fsm #(.WIDTH(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h need=%h", nm, got, exp);
    end
  endtask

  initial begin
    exp8_t e;
    forever begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL done8_unexpected got sum=%h need no done",
                   bus8.sum);
        end else begin
          e = q8.pop_front();
`ifdef SERIAL_ADDER_SUB_EN
          if ({bus8.cout, bus8.sum, bus8.ovf} !== {e.c, e.s, e.v}) begin
            bad++;
            $display("FAIL res8 got c=%b s=%h v=%b need c=%b s=%h v=%b",
                     bus8.cout, bus8.sum, bus8.ovf, e.c, e.s, e.v);
          end
`else
          if ({bus8.cout, bus8.sum} !== {e.c, e.s}) begin
            bad++;
            $display("FAIL res8 got c=%b s=%h need c=%b s=%h",
                     bus8.cout, bus8.sum, e.c, e.s);
          end
`endif
        end
      end
    end
  end

  initial begin
    exp1_t e;
    forever begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL done1_unexpected got sum=%b need no done",
                   bus1.sum);
        end else begin
          e = q1.pop_front();
          if ({bus1.cout, bus1.sum} !== {e.c, e.s}) begin
            bad++;
            $display("FAIL res1 got %b%b need %b%b",
                     bus1.cout, bus1.sum, e.c, e.s);
          end
        end
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input bit push,
                        input logic [7:0] es, input logic ec,
                        input logic ev);
    exp8_t e;
    @(negedge clk);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub   = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
    bus8.start = 1'b1;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.v = ev;
      q8.push_back(e);
    end
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(input string nm);
    int n;
    n = 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got no done need done", nm);
    end
  endtask

  initial begin
    int bc;
    logic dn;
    exp1_t e1;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    chk("rst1_sum", 32'({bus1.cout, bus1.sum}), 32'd0);
    rst_n = 1'b1;

    issue8(8'h3C, 8'h5A, 1'b0, 1'b0, 1, 8'h96, 1'b0, 1'b1);
    bc = 0;
    dn = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) @(negedge clk);
      if (bus8.busy === 1'b1) bc++;
      if (n == 9) dn = bus8.done;
    end
    chk("busy_cycles", 32'(bc), 32'd8);
    chk("done_latency", 32'(dn), 32'd1);
    @(negedge clk);
    chk("done_pulse_end", 32'(bus8.done), 32'd0);
    chk("sum_held_idle", 32'(bus8.sum), 32'h96);

    issue8(8'hFF, 8'h01, 1'b1, 1'b0, 1, 8'h01, 1'b1, 1'b0);
    wait_done8("ff01");
    issue8(8'h80, 8'h80, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b1);
    wait_done8("8080");
    issue8(8'h00, 8'h00, 1'b1, 1'b0, 1, 8'h01, 1'b0, 1'b0);
    wait_done8("0000c");

    issue8(8'h3C, 8'h5A, 1'b0, 1'b0, 1, 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus8.a = 8'h00;
    bus8.b = 8'h00;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("ignored_start");
    repeat (12) @(negedge clk);
    chk("ign_sum", 32'(bus8.sum), 32'h96);
    chk("ign_cout", 32'(bus8.cout), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    issue8(8'h10, 8'h20, 1'b1, 1'b1, 1, 8'hF0, 1'b0, 1'b0);
    wait_done8("sub_1020");
    issue8(8'h80, 8'h01, 1'b1, 1'b1, 1, 8'h7F, 1'b1, 1'b1);
    wait_done8("sub_8001");
    bus8.sub = 1'b0;
`endif

    issue8(8'hAA, 8'h55, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'd0);
    chk("abort_cout", 32'(bus8.cout), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(bus8.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] r;
      v = 3'(i);
      r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      bus1.a     = v[2];
      bus1.b     = v[1];
      bus1.cin   = v[0];
      bus1.start = 1'b1;
      e1.s = r[0];
      e1.c = r[1];
      q1.push_back(e1);
      @(negedge clk);
      @(negedge clk);
      chk("w1_done_every2", 32'(bus1.done), 32'd1);
    end
    bus1.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("w1_idle_after", 32'(bus1.busy), 32'd0);

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
